// File: rtl/deca_sw_ctrl.sv
// Avalon-MM switch controller: 2-flop synchronizer, per-bit debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module deca_sw_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STABLE = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_RAW    = 2'd3;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [WIDTH-1:0] edge_evt;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic             unused_wd;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign wr_en     = chipselect & ~write_n;
    assign wr_bits   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Any sample matching the accepted level resets the count: no partial credit.
    always_comb begin
        stable_d = stable_q;
        edge_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                    edge_evt[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A fresh edge event wins over a simultaneous write-1-to-clear.
    always_comb begin
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_en && (address == ADDR_MASK)) begin
            irq_mask_d = wr_bits;
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_capture_d = edge_capture_q & ~wr_bits;
        end
        edge_capture_d = edge_capture_d | edge_evt;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STABLE: readdata_d = zext(stable_q);
            ADDR_MASK:   readdata_d = zext(irq_mask_q);
            ADDR_EDGE:   readdata_d = zext(edge_capture_q);
            ADDR_RAW:    readdata_d = zext(s2_q);
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q           <= '0;
            s2_q           <= '0;
            stable_q       <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q           <= in_port;
            s2_q           <= s1_q;
            stable_q       <= stable_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_deca_sw_ctrl.sv
// Scoreboard bench for deca_sw_ctrl: a sample-window reference model queues
// the expected readdata/irq every edge, a negedge monitor pops and compares.
module tb_deca_sw_ctrl;

    localparam int W = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] in_port = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    deca_sw_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronized
    // samples all disagree with the current accepted level.
    logic [W-1:0] m_s1, m_s2, m_stable, m_mask, m_ec;
    logic [W-1:0] hist[$];
    logic [31:0]  rdq[$];
    logic         irqq[$];
    logic [W-1:0] m_chg, m_clr;
    logic [31:0]  m_rv;
    logic         m_all;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_ec = '0;
            hist.delete();
            rdq.delete();
            irqq.delete();
        end else begin
            case (address)
                2'd0:    m_rv = {30'd0, m_stable};
                2'd1:    m_rv = {30'd0, m_mask};
                2'd2:    m_rv = {30'd0, m_ec};
                default: m_rv = {30'd0, m_s2};
            endcase
            rdq.push_back(m_rv);
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_chg = '0;
            if (hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    m_all = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == m_stable[i]) m_all = 1'b0;
                    m_chg[i] = m_all;
                end
            end
            m_stable = m_stable ^ m_chg;
            m_clr = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : '0;
            if (chipselect && !write_n && address == 2'd1) m_mask = writedata[W-1:0];
            m_ec = (m_ec & ~m_clr) | m_chg;
            m_s2 = m_s1;
            m_s1 = in_port;
            irqq.push_back(|(m_ec & m_mask));
        end
    end

    logic [31:0] mon_rd;
    logic        mon_irq;

    always @(negedge clk) begin
        if (reset_n && rdq.size() > 0) begin
            mon_rd = rdq.pop_front();
            check("readdata", readdata, mon_rd);
        end
        if (reset_n && irqq.size() > 0) begin
            mon_irq = irqq.pop_front();
            check("irq", {31'd0, irq}, {31'd0, mon_irq});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
    endtask

    logic [31:0] exp_pulse [8] = '{32'd1, 32'd1, 32'd3, 32'd3, 32'd3, 32'd1, 32'd1, 32'd1};
    int hold;

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Basic debounce latency with mask cleared
        in_port = 2'b01;
        repeat (6) tick();
        check("t1_irq_masked", {31'd0, irq}, 32'd0);
        check("t1_stable_before", readdata, 32'd0);
        tick();
        check("t1_stable_after", readdata, 32'd1);
        address = 2'd2;
        tick();
        check("t1_edge_capture", readdata, 32'd1);
        wr(2'd2, 32'd1);

        // Masked interrupt on a rising edge, then cleared
        wr(2'd1, 32'd1);
        in_port = 2'b00;
        repeat (8) tick();
        wr(2'd2, 32'd1);
        in_port = 2'b01;
        repeat (5) tick();
        check("t2_irq_before", {31'd0, irq}, 32'd0);
        tick();
        check("t2_irq_rise", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'd1);
        check("t2_irq_cleared", {31'd0, irq}, 32'd0);
        address = 2'd2;
        tick();
        check("t2_ec_cleared", readdata, 32'd0);

        // Short pulse is rejected but visible on the raw register
        address = 2'd3;
        in_port = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t3_raw", readdata, exp_pulse[k]);
            if (k == 2) in_port = 2'b01;
        end
        address = 2'd0;
        tick();
        check("t3_stable", readdata, 32'd1);
        address = 2'd2;
        tick();
        check("t3_ec", readdata, 32'd0);

        // W1C on the same edge as the new event
        in_port = 2'b11;
        repeat (5) tick();
        wr(2'd2, 32'd2);
        address = 2'd2;
        tick();
        check("t4_set_wins", readdata, 32'd2);

        // Reset mid-count discards progress
        in_port = 2'b00;
        repeat (8) tick();
        wr(2'd2, 32'd3);
        in_port = 2'b11;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("t5_reset_readdata", readdata, 32'd0);
        check("t5_reset_irq", {31'd0, irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (6) tick();
        check("t5_stable_before", readdata, 32'd0);
        tick();
        check("t5_stable_after", readdata, 32'd3);
        address = 2'd2;
        tick();
        check("t5_ec", readdata, 32'd3);

        // Upper write bits and read-only addresses ignored
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        address = 2'd1;
        tick();
        check("t6_mask", readdata, 32'd3);
        address = 2'd0;
        tick();
        check("t6_stable", readdata, 32'd3);

        // Randomized traffic against the model
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                in_port = W'($urandom_range(0, 3));
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 7) != 0);
            write_n    = ($urandom_range(0, 5) != 0);
            tick();
        end
        write_n    = 1'b1;
        chipselect = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
